// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that merges byte-stream requesters into one UART character FIFO, with an optional source tag byte per message.
// Grant is registered one cycle after a valid is seen in IDLE; data req_ready is combinational !char_fifo_full for the owner only.
module uart_tx_arb #(
  parameter int NUM_REQ = 3,
  parameter int TAG_EN  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_tx,
  input  logic                   rst_clk_tx_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   char_fifo_full,
  output logic                   char_fifo_wr_en,
  output logic [7:0]             char_fifo_din,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [15:0]         stall_q, stall_d;

  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       ptr_after;

  // First valid requester at or above ptr, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  assign ptr_after = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gidx_d          = gidx_q;
    ptr_d           = ptr_q;
    stall_d         = stall_q;
    req_ready       = '0;
    char_fifo_wr_en = 1'b0;
    char_fifo_din   = 8'h00;
    err_timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = (TAG_EN != 0) ? TAG : DATA;
        end
      end
      TAG: begin
        stall_d = '0;
        if (!char_fifo_full) begin
          char_fifo_wr_en = 1'b1;
          char_fifo_din   = 8'h30 + 8'(gidx_q);
          state_d         = DATA;
        end
      end
      DATA: begin
        req_ready[gidx_q] = !char_fifo_full;
        if (req_valid[gidx_q] && !char_fifo_full) begin
          char_fifo_wr_en = 1'b1;
          char_fifo_din   = req_data[8*gidx_q +: 8];
          stall_d         = '0;
          if (req_last[gidx_q]) begin
            grant_d = '0;
            ptr_d   = ptr_after;
            state_d = IDLE;
          end
        end else if (!req_valid[gidx_q] && !char_fifo_full) begin
          // Abort on the idle cycle that brings the count up to TIMEOUT.
          if (stall_q == 16'(TIMEOUT - 1)) begin
            err_timeout = 1'b1;
            grant_d     = '0;
            ptr_d       = ptr_after;
            state_d     = IDLE;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: cycle table, directed corner sequences, and randomized traffic against a message-level model.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [2:0]  a_valid = '0, a_last = '0, a_ready, a_grant;
  logic [23:0] a_data = '0;
  logic        a_full = 1'b0, a_wr, a_busy, a_err;
  logic [7:0]  a_din;

  logic [1:0]  b_valid = '0, b_last = '0, b_ready, b_grant;
  logic [15:0] b_data = '0;
  logic        b_full = 1'b0, b_wr, b_busy, b_err;
  logic [7:0]  b_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(3), .TAG_EN(1), .TIMEOUT(4)) u_a (
    .clk_tx(clk), .rst_clk_tx_n(rst_n),
    .req_valid(a_valid), .req_data(a_data), .req_last(a_last), .req_ready(a_ready),
    .char_fifo_full(a_full), .char_fifo_wr_en(a_wr), .char_fifo_din(a_din),
    .grant(a_grant), .busy(a_busy), .err_timeout(a_err)
  );

  uart_tx_arb #(.NUM_REQ(2), .TAG_EN(0), .TIMEOUT(6)) u_b (
    .clk_tx(clk), .rst_clk_tx_n(rst_n),
    .req_valid(b_valid), .req_data(b_data), .req_last(b_last), .req_ready(b_ready),
    .char_fifo_full(b_full), .char_fifo_wr_en(b_wr), .char_fifo_din(b_din),
    .grant(b_grant), .busy(b_busy), .err_timeout(b_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] v; logic [7:0] d; logic l; logic f;
    logic we; logic [7:0] din; logic [2:0] g; logic [2:0] rdy; logic bsy;
  } vec_t;

  function automatic vec_t mk(logic [2:0] v, logic [7:0] d, logic l, logic f,
                              logic we, logic [7:0] din, logic [2:0] g, logic [2:0] rdy, logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.f = f;
    r.we = we; r.din = din; r.g = g; r.rdy = rdy; r.bsy = bsy;
    return r;
  endfunction

  typedef struct packed { logic last; logic [7:0] d; } ent_t;
  ent_t       src_q [3][$];
  logic [7:0] exp_q [$];
  int         mptr = 0;

  // Message-level model: round robin over requesters that still hold messages.
  task automatic build_exp();
    ent_t cp [3][$];
    ent_t e;
    for (int i = 0; i < 3; i++) cp[i] = src_q[i];
    while (cp[0].size() + cp[1].size() + cp[2].size() > 0) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (mptr + k) % 3;
        if (cp[i].size() > 0) begin
          exp_q.push_back(8'(8'h30 + i));
          do begin
            e = cp[i].pop_front();
            exp_q.push_back(e.d);
          end while (!e.last);
          mptr = (i + 1) % 3;
          break;
        end
      end
    end
  endtask

  task automatic run_a(input bit rnd, input int budget);
    int   cyc;
    bit   mid [3];
    int   gap [3];
    ent_t e;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin mid[i] = 1'b0; gap[i] = 0; end
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (src_q[i].size() > 0) begin
          if (rnd && mid[i] && gap[i] < 2 && $urandom_range(0, 3) == 0) begin
            a_valid[i] = 1'b0;
            gap[i]++;
          end else begin
            a_valid[i] = 1'b1;
            gap[i] = 0;
          end
          a_data[8*i +: 8] = src_q[i][0].d;
          a_last[i]        = src_q[i][0].last;
        end else begin
          a_valid[i] = 1'b0;
          a_data[8*i +: 8] = 8'h00;
          a_last[i] = 1'b0;
        end
      end
      a_full = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
      #1;
      chk("wr_while_full", {31'b0, a_wr & a_full}, 32'd0);
      chk("no_timeout", {31'b0, a_err}, 32'd0);
      if (a_wr) begin
        if (exp_q.size() == 0) chk("extra_write", {24'b0, a_din}, 32'hFFFF);
        else chk("fifo_byte", {24'b0, a_din}, {24'b0, exp_q.pop_front()});
      end
      for (int i = 0; i < 3; i++) begin
        if (a_valid[i] && a_ready[i]) begin
          e = src_q[i].pop_front();
          mid[i] = !e.last;
        end
      end
    end
    chk("stream_done", exp_q.size(), 32'd0);
    @(negedge clk);
    a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
    mptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"}, {29'b0, a_grant}, 32'd0);
    chk({tag, "_busy"},  {31'b0, a_busy},  32'd0);
    chk({tag, "_wr"},    {31'b0, a_wr},    32'd0);
    chk({tag, "_din"},   {24'b0, a_din},   32'd0);
    chk({tag, "_ready"}, {29'b0, a_ready}, 32'd0);
    chk({tag, "_err"},   {31'b0, a_err},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [16];
    ent_t e;
    int   n, i0, i1;
    logic [7:0] bexp;

    // Reset state
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester 1 message, then a 3-byte message with a 5-cycle full stall
    tbl[0]  = mk(3'b010, 8'h41, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[1]  = mk(3'b010, 8'h41, 0, 0, 1, 8'h31, 3'b010, 3'b000, 1);
    tbl[2]  = mk(3'b010, 8'h41, 0, 0, 1, 8'h41, 3'b010, 3'b010, 1);
    tbl[3]  = mk(3'b010, 8'h42, 1, 0, 1, 8'h42, 3'b010, 3'b010, 1);
    tbl[4]  = mk(3'b000, 8'h00, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[5]  = mk(3'b010, 8'h51, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[6]  = mk(3'b010, 8'h51, 0, 0, 1, 8'h31, 3'b010, 3'b000, 1);
    tbl[7]  = mk(3'b010, 8'h51, 0, 0, 1, 8'h51, 3'b010, 3'b010, 1);
    for (int r = 8; r < 13; r++)
      tbl[r] = mk(3'b010, 8'h52, 0, 1, 0, 8'h00, 3'b010, 3'b000, 1);
    tbl[13] = mk(3'b010, 8'h52, 0, 0, 1, 8'h52, 3'b010, 3'b010, 1);
    tbl[14] = mk(3'b010, 8'h53, 1, 0, 1, 8'h53, 3'b010, 3'b010, 1);
    tbl[15] = mk(3'b000, 8'h00, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      a_valid = tbl[r].v;
      a_data  = {8'h00, tbl[r].d, 8'h00};
      a_last  = {1'b0, tbl[r].l, 1'b0};
      a_full  = tbl[r].f;
      #1;
      chk($sformatf("tbl%0d_wr", r),    {31'b0, a_wr},    {31'b0, tbl[r].we});
      chk($sformatf("tbl%0d_din", r),   {24'b0, a_din},   {24'b0, tbl[r].din});
      chk($sformatf("tbl%0d_grant", r), {29'b0, a_grant}, {29'b0, tbl[r].g});
      chk($sformatf("tbl%0d_ready", r), {29'b0, a_ready}, {29'b0, tbl[r].rdy});
      chk($sformatf("tbl%0d_busy", r),  {31'b0, a_busy},  {31'b0, tbl[r].bsy});
      chk($sformatf("tbl%0d_err", r),   {31'b0, a_err},   32'd0);
    end

    // Requesters 0 and 2 from reset, 2-byte messages each
    do_reset();
    e.last = 1'b0; e.d = 8'hA0; src_q[0].push_back(e);
    e.last = 1'b1; e.d = 8'hA1; src_q[0].push_back(e);
    e.last = 1'b0; e.d = 8'hC0; src_q[2].push_back(e);
    e.last = 1'b1; e.d = 8'hC1; src_q[2].push_back(e);
    build_exp();
    chk("rr_order_model_first_tag", {24'b0, exp_q[0]}, 32'h30);
    run_a(1'b0, 50);

    // Randomized traffic continues from the current pointer (all requesters contend)
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 6; m++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          e.last = (b == len - 1);
          e.d    = 8'($urandom);
          src_q[i].push_back(e);
        end
      end
    end
    build_exp();
    run_a(1'b1, 2000);

    // Timeout: requester 0 stalls after one byte, requester 2 is waiting
    do_reset();
    @(negedge clk);
    a_valid = 3'b101; a_data = {8'h70, 8'h00, 8'h60}; a_last = 3'b100;
    #1 chk("to_idle_grant", {29'b0, a_grant}, 32'd0);
    @(negedge clk); #1;
    chk("to_tag", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h30});
    @(negedge clk); #1;
    chk("to_byte", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h60});
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) a_valid = 3'b100;
      #1;
      chk($sformatf("to_err_c%0d", c), {31'b0, a_err}, {31'b0, c == 6});
      chk($sformatf("to_wr_c%0d", c),  {31'b0, a_wr},  32'd0);
    end
    @(negedge clk); #1;
    chk("to_grant_cleared", {29'b0, a_grant}, 32'd0);
    chk("to_err_single", {31'b0, a_err}, 32'd0);
    @(negedge clk); #1;
    chk("to_next_grant", {29'b0, a_grant}, 32'b100);
    chk("to_next_tag", {24'b0, a_din}, 32'h32);
    @(negedge clk); #1;
    chk("to_next_byte", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h70});
    @(negedge clk);
    a_valid = '0; a_last = '0; a_data = '0;

    // Asynchronous reset in DATA of requester 1
    @(negedge clk);
    a_valid = 3'b010; a_data = {8'h00, 8'h81, 8'h00}; a_last = 3'b000;
    repeat (2) @(negedge clk);
    #1 chk("ar_byte", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h81});
    @(negedge clk);
    a_data = {8'h00, 8'h82, 8'h90}; a_last = 3'b001;
    #1 chk("ar_in_data", {31'b0, a_busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    @(negedge clk);
    a_valid = 3'b011;
    rst_n = 1'b1;
    #1 chk("ar_idle_wr", {31'b0, a_wr}, 32'd0);
    @(negedge clk); #1;
    chk("ar_grant0", {29'b0, a_grant}, 32'b001);
    chk("ar_tag0", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h30});
    @(negedge clk); #1;
    chk("ar_byte0", {23'b0, a_wr, a_din}, {23'b0, 1'b1, 8'h90});
    @(negedge clk);
    a_valid = '0; a_last = '0; a_data = '0;

    // Untagged two-requester alternation on the second instance
    n = 0; i0 = 0; i1 = 0;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(negedge clk);
      b_valid = 2'b11; b_last = 2'b11;
      b_data  = {8'(8'hB0 + i1), 8'(8'hA0 + i0)};
      #1;
      chk("alt_no_err", {31'b0, b_err}, 32'd0);
      if (b_wr) begin
        bexp = (n % 2 == 0) ? 8'(8'hA0 + n / 2) : 8'(8'hB0 + n / 2);
        chk($sformatf("alt_byte%0d", n), {24'b0, b_din}, {24'b0, bexp});
        n++;
      end
      if (b_valid[0] && b_ready[0]) i0++;
      if (b_valid[1] && b_ready[1]) i1++;
    end
    chk("alt_count", n, 32'd4);
    @(negedge clk);
    b_valid = '0; b_last = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
